// File: rtl/systolic_writeback.sv
// Writeback stage: sweeps the systolic array read-out slots, quantizes each lane to
// OUT_WIDTH bits and writes packed rows to the output SRAM. Optional ReLU: WB_RELU_EN.

module wb_lane_quant #(
  parameter int OUTCOME_WIDTH = 29,
  parameter int OUT_WIDTH     = 8
) (
  input  logic signed [OUTCOME_WIDTH-1:0] acc,
  input  logic        [4:0]               shift,
  output logic        [OUT_WIDTH-1:0]     q
);
  localparam int W = OUTCOME_WIDTH + 1;
  localparam logic signed [OUT_WIDTH-1:0] MAX_O = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] MIN_O = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  localparam logic signed [W-1:0] MAX_W = {{(W-OUT_WIDTH){1'b0}}, MAX_O};
  localparam logic signed [W-1:0] MIN_W = {{(W-OUT_WIDTH){1'b1}}, MIN_O};

  logic signed [W-1:0] ext, rnd, sum, shr;
  logic signed [OUT_WIDTH-1:0] sat;

  // One guard bit keeps the rounding add from overflowing at the top of the range.
  always_comb begin
    ext = {acc[OUTCOME_WIDTH-1], acc};
    rnd = '0;
    if (shift != 5'd0) rnd = W'(1) << (shift - 5'd1);
    sum = ext + rnd;
    shr = sum >>> shift;
    if (shr > MAX_W)      sat = MAX_O;
    else if (shr < MIN_W) sat = MIN_O;
    else                  sat = shr[OUT_WIDTH-1:0];
  end

`ifdef WB_RELU_EN
  assign q = sat[OUT_WIDTH-1] ? '0 : sat;
`else
  assign q = sat;
`endif
endmodule

module systolic_writeback #(
  parameter int ARRAY_SIZE    = 16,
  parameter int OUTCOME_WIDTH = 29,
  parameter int OUT_WIDTH     = 8,
  parameter int ADDR_WIDTH    = 10
) (
  input  logic                            clk,
  input  logic                            srstn,
  input  logic                            wb_start,
  input  logic [ADDR_WIDTH-1:0]           base_addr,
  input  logic [4:0]                      shift,
  output logic [5:0]                      matrix_index,
  input  logic [ARRAY_SIZE*OUTCOME_WIDTH-1:0] mul_outcome,
  output logic                            sram_wen,
  output logic [ADDR_WIDTH-1:0]           sram_waddr,
  output logic [ARRAY_SIZE*OUT_WIDTH-1:0] sram_wdata,
  input  logic                            sram_wready,
  output logic                            busy,
  output logic                            done
);
  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] base;
    logic [4:0]            shift;
  } cfg_t;

  localparam logic [4:0] MAX_SHIFT = 5'(OUTCOME_WIDTH - 1);
  localparam logic [5:0] LAST_IDX  = 6'(ARRAY_SIZE - 1);

  state_t state, state_nx;
  cfg_t   cfg;
  logic [5:0] idx;
  logic       last;

  logic [ARRAY_SIZE-1:0][OUT_WIDTH-1:0] q_lane;
  logic [ARRAY_SIZE*OUT_WIDTH-1:0]      row;

  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    wb_lane_quant #(.OUTCOME_WIDTH(OUTCOME_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_quant (
      .acc   (mul_outcome[i*OUTCOME_WIDTH +: OUTCOME_WIDTH]),
      .shift (cfg.shift),
      .q     (q_lane[i])
    );
    // Lane 0 lands in the most significant byte of the row.
    assign row[(ARRAY_SIZE-1-i)*OUT_WIDTH +: OUT_WIDTH] = q_lane[i];
  end

  assign last = (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!srstn) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (wb_start) state_nx = FETCH;
      FETCH:   state_nx = WRITE;
      WRITE:   if (sram_wready) state_nx = last ? DONE : FETCH;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!srstn) begin
      cfg        <= '0;
      idx        <= '0;
      sram_waddr <= '0;
      sram_wdata <= '0;
    end else begin
      case (state)
        IDLE: if (wb_start) begin
          cfg.base  <= base_addr;
          cfg.shift <= (shift > MAX_SHIFT) ? MAX_SHIFT : shift;
          idx       <= '0;
        end
        FETCH: begin
          sram_wdata <= row;
          sram_waddr <= cfg.base + ADDR_WIDTH'(idx);
        end
        WRITE: if (sram_wready && !last) idx <= idx + 6'd1;
        default: ;
      endcase
    end
  end

  assign matrix_index = idx;
  assign sram_wen     = (state == WRITE);
  assign busy         = (state == FETCH) || (state == WRITE);
  assign done         = (state == DONE);
endmodule
